// File: rtl/mult_div_unit.sv
// Iterative 32-step multiply/divide unit producing MIPS-style HI/LO results.
// One shift-add (multiply) or restoring shift-subtract (divide) step per clock.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       operation,
  input  logic [WIDTH-1:0] operandA,
  input  logic [WIDTH-1:0] operandB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             divideByZero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      count_q, count_d;
  logic [1:0]         op_q, op_d;
  logic               signA_q, signA_d;
  logic               signB_q, signB_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   addend_q, addend_d;
  logic [WIDTH-1:0]   origA_q, origA_d;
  logic               divZero_q, divZero_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               dbz_q, dbz_d;
  logic               done_q, done_d;

  // Start-time operand conditioning: signed ops work on magnitudes.
  logic               startSigned;
  logic               startIsDiv;
  logic [WIDTH-1:0]   absA;
  logic [WIDTH-1:0]   absB;

  // acc holds {partial product, multiplier} for multiply, {unused, dividend/quotient} for divide.
  logic [WIDTH:0]     mulSum;
  logic [2*WIDTH-1:0] mulNext;
  logic [WIDTH:0]     divShift;
  logic               divFits;
  logic [WIDTH-1:0]   divDiff;
  logic [WIDTH-1:0]   remNext;
  logic [WIDTH-1:0]   quoNext;

  logic               negResult;
  logic               negRemainder;
  logic [2*WIDTH-1:0] prodResult;
  logic [WIDTH-1:0]   quoResult;
  logic [WIDTH-1:0]   remResult;

  assign startSigned = operation[0];
  assign startIsDiv  = operation[1];
  assign absA = (startSigned && operandA[WIDTH-1]) ? -operandA : operandA;
  assign absB = (startSigned && operandB[WIDTH-1]) ? -operandB : operandB;

  assign mulSum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, addend_q} : '0);
  assign mulNext = {mulSum, acc_q[WIDTH-1:1]};

  // The shifted remainder is below twice the divisor, so the low WIDTH bits of the difference suffice.
  assign divShift = {rem_q, acc_q[WIDTH-1]};
  assign divFits  = (divShift >= {1'b0, addend_q});
  assign divDiff  = divShift[WIDTH-1:0] - addend_q;
  assign remNext  = divFits ? divDiff : divShift[WIDTH-1:0];
  assign quoNext  = {acc_q[WIDTH-2:0], divFits};

  assign negResult    = op_q[0] & (signA_q ^ signB_q);
  assign negRemainder = op_q[0] & signA_q;
  assign prodResult   = negResult ? -mulNext : mulNext;
  assign quoResult    = negResult ? -quoNext : quoNext;
  assign remResult    = negRemainder ? -remNext : remNext;

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    op_d      = op_q;
    signA_d   = signA_q;
    signB_d   = signB_q;
    acc_d     = acc_q;
    rem_d     = rem_q;
    addend_d  = addend_q;
    origA_d   = origA_q;
    divZero_d = divZero_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    dbz_d     = dbz_q;
    done_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = RUN;
          count_d   = '0;
          op_d      = operation;
          signA_d   = startSigned & operandA[WIDTH-1];
          signB_d   = startSigned & operandB[WIDTH-1];
          acc_d     = {{WIDTH{1'b0}}, (startIsDiv ? absA : absB)};
          addend_d  = startIsDiv ? absB : absA;
          rem_d     = '0;
          origA_d   = operandA;
          divZero_d = (operandB == '0);
        end
      end
      RUN: begin
        count_d = count_q + CW'(1);
        if (op_q[1]) begin
          acc_d[WIDTH-1:0] = quoNext;
          rem_d            = remNext;
        end else begin
          acc_d = mulNext;
        end
        // Final step publishes the corrected result directly from the step logic.
        if (count_q == LAST_STEP) begin
          state_d = IDLE;
          count_d = '0;
          done_d  = 1'b1;
          dbz_d   = 1'b0;
          if (!op_q[1]) begin
            hi_d = prodResult[2*WIDTH-1:WIDTH];
            lo_d = prodResult[WIDTH-1:0];
          end else if (divZero_q) begin
            hi_d  = origA_q;
            lo_d  = '1;
            dbz_d = 1'b1;
          end else begin
            hi_d = remResult;
            lo_d = quoResult;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      count_q   <= '0;
      op_q      <= '0;
      signA_q   <= 1'b0;
      signB_q   <= 1'b0;
      acc_q     <= '0;
      rem_q     <= '0;
      addend_q  <= '0;
      origA_q   <= '0;
      divZero_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      dbz_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      op_q      <= op_d;
      signA_q   <= signA_d;
      signB_q   <= signB_d;
      acc_q     <= acc_d;
      rem_q     <= rem_d;
      addend_q  <= addend_d;
      origA_q   <= origA_d;
      divZero_q <= divZero_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      dbz_q     <= dbz_d;
      done_q    <= done_d;
    end
  end

  assign busy         = (state_q == RUN);
  assign done         = done_q;
  assign hi           = hi_q;
  assign lo           = lo_q;
  assign divideByZero = dbz_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed cases from the handshake rules
// plus random operations compared against a plain-arithmetic reference model.
module tb_mult_div_unit;

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  operation;
  logic [31:0] operandA;
  logic [31:0] operandB;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        divideByZero;

  int          testCount = 0;
  int          failCount = 0;
  logic [31:0] prevHi = '0;
  logic [31:0] prevLo = '0;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .operation    (operation),
    .operandA     (operandA),
    .operandB     (operandB),
    .busy         (busy),
    .done         (done),
    .hi           (hi),
    .lo           (lo),
    .divideByZero (divideByZero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    testCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Reference results straight from the arithmetic definitions of each operation.
  task automatic refModel(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] eHi, output logic [31:0] eLo, output logic eDbz);
    logic [63:0] up;
    longint      sa, sb, sp, sq, sr;
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    eDbz = 1'b0;
    case (op)
      OP_MULTU: begin
        up  = {32'b0, a} * {32'b0, b};
        eHi = up[63:32];
        eLo = up[31:0];
      end
      OP_MULT: begin
        sp  = sa * sb;
        eHi = sp[63:32];
        eLo = sp[31:0];
      end
      default: begin
        if (b == 32'd0) begin
          eHi  = a;
          eLo  = 32'hFFFF_FFFF;
          eDbz = 1'b1;
        end else if (op == OP_DIVU) begin
          eHi = a % b;
          eLo = a / b;
        end else begin
          sq  = sa / sb;
          sr  = sa % sb;
          eHi = sr[31:0];
          eLo = sq[31:0];
        end
      end
    endcase
  endtask

  // Presents one start request; returns just after the sampling edge E0.
  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    operation = op;
    operandA  = a;
    operandB  = b;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Counts edges until done, bounded; also checks HI/LO stay frozen mid-run.
  task automatic waitDone(output int cyc);
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == 16) begin
        checkOutput("holdHi", hi, prevHi);
        checkOutput("holdLo", lo, prevLo);
      end
    end while (!done && cyc < 40);
    if (!done) checkOutput("doneTimeout", done, 1'b1);
  endtask

  task automatic runOp(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] eHi, eLo;
    logic        eDbz;
    int          cyc;
    refModel(op, a, b, eHi, eLo, eDbz);
    applyStimulus(op, a, b);
    checkOutput({tag, ".busyAtStart"}, busy, 1'b1);
    checkOutput({tag, ".doneLowAtStart"}, done, 1'b0);
    waitDone(cyc);
    checkOutput({tag, ".latency"}, cyc, 32);
    checkOutput({tag, ".busyAtDone"}, busy, 1'b0);
    checkOutput({tag, ".hi"}, hi, eHi);
    checkOutput({tag, ".lo"}, lo, eLo);
    checkOutput({tag, ".dbz"}, divideByZero, eDbz);
    prevHi = eHi;
    prevLo = eLo;
  endtask

  initial begin
    int          cyc;
    logic        sawDone;
    logic [1:0]  rOp;
    logic [31:0] rA, rB;
    int          pick;

    reset     = 1'b0;
    start     = 1'b0;
    operation = OP_MULTU;
    operandA  = '0;
    operandB  = '0;

    // Asynchronous reset before any clock edge.
    #3 reset = 1'b1;
    #1;
    checkOutput("rst.busy", busy, 1'b0);
    checkOutput("rst.done", done, 1'b0);
    checkOutput("rst.hi", hi, 32'd0);
    checkOutput("rst.lo", lo, 32'd0);
    checkOutput("rst.dbz", divideByZero, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("idle.busy", busy, 1'b0);
    checkOutput("idle.done", done, 1'b0);

    // Directed arithmetic cases.
    runOp("multuMax", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    checkOutput("multuMax.hiConst", hi, 32'hFFFF_FFFE);
    checkOutput("multuMax.loConst", lo, 32'h0000_0001);
    runOp("multNeg", OP_MULT, 32'hFFFF_FFFD, 32'd7);
    checkOutput("multNeg.loConst", lo, 32'hFFFF_FFEB);
    runOp("divNeg", OP_DIV, 32'hFFFF_FFF9, 32'd2);
    checkOutput("divNeg.loConst", lo, 32'hFFFF_FFFD);
    runOp("divOvf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    checkOutput("divOvf.loConst", lo, 32'h8000_0000);
    runOp("divuZero", OP_DIVU, 32'd100, 32'd0);
    checkOutput("divuZero.hiConst", hi, 32'h0000_0064);
    runOp("divuAfterZero", OP_DIVU, 32'd100, 32'd7);
    runOp("divZeroSigned", OP_DIV, 32'hFFFF_FF00, 32'd0);

    // Start pulsed mid-run must not disturb the operation in flight.
    applyStimulus(OP_MULTU, 32'd5, 32'd6);
    repeat (9) @(posedge clk);
    #1;
    operandA = 32'd9;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    waitDone(cyc);
    checkOutput("ignStart.latency", cyc + 10, 32);
    checkOutput("ignStart.lo", lo, 32'd30);
    checkOutput("ignStart.hi", hi, 32'd0);
    prevHi = 32'd0;
    prevLo = 32'd30;

    // Start held across E32 is ignored there and captured at E33.
    applyStimulus(OP_MULTU, 32'd10, 32'd20);
    repeat (31) @(posedge clk);
    #1;
    operation = OP_DIVU;
    operandA  = 32'd100;
    operandB  = 32'd7;
    start     = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("b2b.doneAtE32", done, 1'b1);
    checkOutput("b2b.busyAtE32", busy, 1'b0);
    checkOutput("b2b.lo", lo, 32'd200);
    prevHi = 32'd0;
    prevLo = 32'd200;
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput("b2b.busyAtE33", busy, 1'b1);
    checkOutput("b2b.doneAtE33", done, 1'b0);
    waitDone(cyc);
    checkOutput("b2b.latency2", cyc, 32);
    checkOutput("b2b.lo2", lo, 32'd14);
    checkOutput("b2b.hi2", hi, 32'd2);
    prevHi = 32'd2;
    prevLo = 32'd14;

    // Reset mid-operation aborts with no done.
    applyStimulus(OP_MULT, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (15) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    checkOutput("abort.busy", busy, 1'b0);
    checkOutput("abort.hi", hi, 32'd0);
    checkOutput("abort.lo", lo, 32'd0);
    @(negedge clk);
    reset   = 1'b0;
    sawDone = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      sawDone = sawDone | done | busy;
    end
    checkOutput("abort.noDone", sawDone, 1'b0);
    prevHi = 32'd0;
    prevLo = 32'd0;

    // Random operations with boundary operands mixed in.
    for (int i = 0; i < 24; i++) begin
      rOp  = 2'($urandom_range(0, 3));
      rA   = $urandom;
      pick = $urandom_range(0, 7);
      if (pick == 0)      rB = 32'd0;
      else if (pick == 1) rB = 32'hFFFF_FFFF;
      else if (pick == 2) rB = 32'($urandom_range(1, 15));
      else                rB = $urandom;
      if ($urandom_range(0, 5) == 0) rA = 32'h8000_0000;
      runOp($sformatf("rand%0d", i), rOp, rA, rB);
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
